// File: rtl/llc_pkg.sv
// Shared LLC widths, address types and the stall-tracker sweep state encoding.
package llc_pkg;

  localparam int LLC_SET_BITS   = 8;
  localparam int LLC_TAG_BITS   = 18;
  localparam int LINE_ADDR_BITS = LLC_SET_BITS + LLC_TAG_BITS;

  typedef logic [LLC_SET_BITS-1:0]   llc_set_t;
  typedef logic [LLC_TAG_BITS-1:0]   llc_tag_t;
  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;

  typedef enum logic [1:0] {
    STALL_IDLE        = 2'd0,
    STALL_RST_SWEEP   = 2'd1,
    STALL_FLUSH_SWEEP = 2'd2
  } stall_state_t;

endpackage

// File: rtl/llc_sweep_counter.sv
// Set counter walked by the reset/flush sweep; clear has priority over incr.
module llc_sweep_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             incr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= count + WIDTH'(1);
    end
  end

  // High on the step that takes the last set back to zero.
  assign wrap = incr & (&count);

endmodule

// File: rtl/llc_stall_tracker.sv
// LLC stall/resume bookkeeping between the input arbiter and set-select:
// reset/flush sweep FSM, stalled-request capture and the DMA line address.
module llc_stall_tracker
  import llc_pkg::*;
#(
  parameter int SET_BITS   = LLC_SET_BITS,
  parameter int TAG_BITS   = LLC_TAG_BITS,
  parameter int LADDR_BITS = SET_BITS + TAG_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_rst,
  input  logic                  start_flush,
  input  logic                  pipe_idle,
  input  logic                  set_req_stall,
  input  logic [SET_BITS-1:0]   stall_set,
  input  logic [TAG_BITS-1:0]   stall_tag,
  input  logic                  incr_rst_flush_stalled_set,
  input  logic                  clr_rst_stall,
  input  logic                  clr_flush_stall,
  input  logic                  clr_req_stall,
  input  logic                  update_dma_addr_from_req,
  input  logic                  dma_start,
  input  logic [LADDR_BITS-1:0] dma_req_in_addr,
  output logic                  rst_stall,
  output logic                  flush_stall,
  output logic                  req_stall,
  output logic [SET_BITS-1:0]   rst_flush_stalled_set,
  output logic [SET_BITS-1:0]   req_in_stalled_set,
  output logic [TAG_BITS-1:0]   req_in_stalled_tag,
  output logic                  is_rst_to_resume,
  output logic                  is_flush_to_resume,
  output logic [LADDR_BITS-1:0] dma_addr
);

  stall_state_t state_reg, state_next;
  logic         sweep_done;
  logic         sweep_active;
  logic         sweep_clear;
  logic         sweep_incr;
  logic         sweep_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= STALL_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Reset start wins over flush start; clr only ends the sweep it belongs to.
  always_comb begin
    state_next = state_reg;
    sweep_done = 1'b0;
    case (state_reg)
      STALL_IDLE: begin
        if (start_rst) begin
          state_next = STALL_RST_SWEEP;
        end else if (start_flush) begin
          state_next = STALL_FLUSH_SWEEP;
        end
      end
      STALL_RST_SWEEP: begin
        if (clr_rst_stall) begin
          state_next = STALL_IDLE;
          sweep_done = 1'b1;
        end
      end
      STALL_FLUSH_SWEEP: begin
        if (clr_flush_stall) begin
          state_next = STALL_IDLE;
          sweep_done = 1'b1;
        end
      end
      default: state_next = STALL_IDLE;
    endcase
  end

  always_comb begin
    rst_stall          = (state_reg == STALL_RST_SWEEP);
    flush_stall        = (state_reg == STALL_FLUSH_SWEEP);
    is_rst_to_resume   = rst_stall & pipe_idle;
    is_flush_to_resume = flush_stall & pipe_idle;
  end

  assign sweep_active = (state_reg != STALL_IDLE);
  assign sweep_incr   = sweep_active & incr_rst_flush_stalled_set;
  assign sweep_clear  = sweep_done | (~sweep_active & (state_next != STALL_IDLE));

  llc_sweep_counter #(
    .WIDTH (SET_BITS)
  ) u_sweep_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (sweep_clear),
    .incr  (sweep_incr),
    .count (rst_flush_stalled_set),
    .wrap  (sweep_wrap)
  );

  // A simultaneous set and clr is a release followed by a fresh stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_stall          <= 1'b0;
      req_in_stalled_set <= '0;
      req_in_stalled_tag <= '0;
    end else if (set_req_stall) begin
      req_stall          <= 1'b1;
      req_in_stalled_set <= stall_set;
      req_in_stalled_tag <= stall_tag;
    end else if (clr_req_stall) begin
      req_stall          <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_addr <= '0;
    end else if (dma_start) begin
      dma_addr <= dma_req_in_addr;
    end else if (update_dma_addr_from_req) begin
      dma_addr <= dma_addr + LADDR_BITS'(1);
    end
  end

  a_no_double_stall: assert property (
    @(posedge clk) disable iff (rst)
      (set_req_stall && !clr_req_stall) |-> !req_stall);

  a_clr_on_last_set: assert property (
    @(posedge clk) disable iff (rst)
      ((rst_stall && clr_rst_stall) || (flush_stall && clr_flush_stall)) |-> sweep_wrap);

endmodule
